// File: rtl/fp_adder_arbiter.sv
// Round-robin arbiter sharing one combinational FP adder among requesters.
// Registered single-entry result slot with id tag and sticky exception flags.
module floating_point_adder #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b,
  input  logic                                   subtract,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out,
  output logic [2:0]                             flags
);
  localparam int E  = EXPONENT_WIDTH;
  localparam int M  = MANTISSA_WIDTH;
  localparam int W  = E + M + 1;
  localparam int SW = M + 4;

  logic          w_sb, w_swap, w_xs_n, w_ys_n, w_eff_sub;
  logic [W-1:0]  w_x, w_y;
  logic [E-1:0]  w_xe, w_ye, w_xee, w_yee, w_d;
  logic [M-1:0]  w_xm, w_ym;
  logic          w_xnan, w_ynan, w_xinf, w_yinf;
  logic [SW-1:0] w_xs, w_ys, w_ysh, w_mask, w_al, w_n;
  logic          w_stk, w_rup, w_sign;
  logic [SW:0]   w_sum;
  logic [31:0]   w_e, w_lz, w_sh, w_xe32, w_ef;
  logic [M+1:0]  w_rnd;
  logic [M-1:0]  w_frac;

  assign w_sb   = b[W-1] ^ subtract;
  assign w_swap = b[W-2:0] > a[W-2:0];
  assign w_x    = w_swap ? {w_sb, b[W-2:0]} : a;
  assign w_y    = w_swap ? a : {w_sb, b[W-2:0]};
  assign w_xs_n = w_x[W-1];
  assign w_ys_n = w_y[W-1];
  assign w_xe   = w_x[W-2:M];
  assign w_ye   = w_y[W-2:M];
  assign w_xm   = w_x[M-1:0];
  assign w_ym   = w_y[M-1:0];
  assign w_xnan = (&w_xe) & (|w_xm);
  assign w_ynan = (&w_ye) & (|w_ym);
  assign w_xinf = (&w_xe) & ~(|w_xm);
  assign w_yinf = (&w_ye) & ~(|w_ym);
  assign w_eff_sub = w_xs_n ^ w_ys_n;

  // Subnormals use exponent 1 with no hidden bit.
  assign w_xee  = (w_xe == '0) ? E'(1) : w_xe;
  assign w_yee  = (w_ye == '0) ? E'(1) : w_ye;
  assign w_xs   = {|w_xe, w_xm, 3'b000};
  assign w_ys   = {|w_ye, w_ym, 3'b000};
  assign w_d    = w_xee - w_yee;
  assign w_ysh  = w_ys >> w_d;
  assign w_mask = ~({SW{1'b1}} << w_d);
  assign w_stk  = |(w_ys & w_mask);
  assign w_al   = {w_ysh[SW-1:1], w_ysh[0] | w_stk};
  assign w_sum  = w_eff_sub ? ({1'b0, w_xs} - {1'b0, w_al})
                            : ({1'b0, w_xs} + {1'b0, w_al});
  assign w_xe32 = {{(32-E){1'b0}}, w_xee};

  always_comb begin
    w_lz = 32'(SW);
    for (int i = 0; i < SW; i++)
      if (w_sum[i]) w_lz = 32'(SW - 1 - i);
    w_sh = '0;
    if (w_sum[SW]) begin
      w_n = {w_sum[SW:2], w_sum[1] | w_sum[0]};
      w_e = w_xe32 + 32'd1;
    end else begin
      // Left shift stops at exponent 1 so tiny results stay subnormal.
      w_sh = (w_lz < w_xe32) ? w_lz : (w_xe32 - 32'd1);
      w_n  = w_sum[SW-1:0] << w_sh;
      w_e  = w_xe32 - w_sh;
    end
  end

  assign w_rup  = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
  assign w_rnd  = {1'b0, w_n[SW-1:3]} + {{(M+1){1'b0}}, w_rup};
  assign w_ef   = w_rnd[M+1] ? (w_e + 32'd1) : (w_rnd[M] ? w_e : 32'd0);
  assign w_frac = w_rnd[M+1] ? '0 : w_rnd[M-1:0];
  assign w_sign = (w_sum == '0) ? (w_xs_n & w_ys_n) : w_xs_n;

  always_comb begin
    out   = '0;
    flags = 3'b000;
    if (w_xnan || w_ynan || (w_xinf && w_yinf && w_eff_sub)) begin
      out   = {1'b1, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
      flags = 3'b001;
    end else if (w_xinf) begin
      out   = {w_xs_n, {E{1'b1}}, {M{1'b0}}};
      flags = 3'b010;
    end else if (w_ef >= ((32'd1 << E) - 32'd1)) begin
      out   = {w_sign, {E{1'b1}}, {M{1'b0}}};
      flags = 3'b010;
    end else begin
      out   = {w_sign, w_ef[E-1:0], w_frac};
      flags = {(w_ef == 32'd0) && (w_frac != '0), 2'b00};
    end
  end
endmodule

module fp_adder_arbiter #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int NUM_REQ        = 4,
  parameter int ID_WIDTH       = 2
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic [NUM_REQ-1:0]                               req_valid,
  output logic [NUM_REQ-1:0]                               req_ready,
  input  logic [NUM_REQ*(EXPONENT_WIDTH+MANTISSA_WIDTH+1)-1:0] req_a,
  input  logic [NUM_REQ*(EXPONENT_WIDTH+MANTISSA_WIDTH+1)-1:0] req_b,
  input  logic [NUM_REQ-1:0]                               req_subtract,
  output logic                                             rsp_valid,
  input  logic                                             rsp_ready,
  output logic [ID_WIDTH-1:0]                              rsp_id,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]           rsp_result,
  output logic [2:0]                                       rsp_flags,
  output logic [2:0]                                       sticky_flags,
  input  logic                                             clear_sticky
);
  localparam int W = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;

  typedef enum logic {S_EMPTY, S_FULL} state_e;

  state_e              r_state, w_state_nxt;
  logic [ID_WIDTH-1:0] r_ptr, r_id, w_gnt, w_ptr_nxt;
  logic [W-1:0]        r_result, w_a, w_b, w_sum;
  logic [2:0]          r_flags, r_sticky, w_flags;
  logic                w_any, w_can, w_acc, w_sub;

  always_comb begin
    w_gnt = '0;
    w_any = 1'b0;
    // Descending scan so the nearest index after ptr wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_gnt = ID_WIDTH'((int'(r_ptr) + k) % NUM_REQ);
        w_any = 1'b1;
      end
    end
  end

  assign rsp_valid = (r_state == S_FULL);
  assign w_can     = rst_n & (~rsp_valid | rsp_ready);
  assign w_acc     = w_any & w_can;

  always_comb begin
    req_ready = '0;
    if (w_acc) req_ready[w_gnt] = 1'b1;
  end

  assign w_a   = req_a[int'(w_gnt)*W +: W];
  assign w_b   = req_b[int'(w_gnt)*W +: W];
  assign w_sub = req_subtract[w_gnt];
  assign w_ptr_nxt = (w_gnt == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                       : w_gnt + 1'b1;

  floating_point_adder #(
    .EXPONENT_WIDTH(EXPONENT_WIDTH),
    .MANTISSA_WIDTH(MANTISSA_WIDTH)
  ) u_add (
    .a       (w_a),
    .b       (w_b),
    .subtract(w_sub),
    .out     (w_sum),
    .flags   (w_flags)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_acc) w_state_nxt = S_FULL;
      S_FULL:  if (rsp_ready && !w_acc) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_EMPTY;
      r_ptr    <= '0;
      r_id     <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc) begin
        r_ptr    <= w_ptr_nxt;
        r_id     <= w_gnt;
        r_result <= w_sum;
        r_flags  <= w_flags;
      end
    end
  end

  // Clear takes priority, but the flags of a same-cycle handshake survive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_sticky <= '0;
    else if (rsp_valid && rsp_ready)
      r_sticky <= (clear_sticky ? 3'b000 : r_sticky) | r_flags;
    else if (clear_sticky)
      r_sticky <= '0;
  end

  assign rsp_id       = r_id;
  assign rsp_result   = r_result;
  assign rsp_flags    = r_flags;
  assign sticky_flags = r_sticky;
endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Directed bench for fp_adder_arbiter: handshake, fairness,
// backpressure, exceptions, rounding and reset behaviour.
module tb_fp_adder_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a, req_b;
  logic [3:0]   req_subtract;
  logic         rsp_valid, rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_result;
  logic [2:0]   rsp_flags, sticky_flags;
  logic         clear_sticky;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] fa [4] = '{32'h3F800000, 32'h40000000,
                          32'h40400000, 32'h40800000};
  logic [31:0] fb [4] = '{32'h3F800000, 32'h3F800000,
                          32'h3F800000, 32'h3F000000};
  logic        fs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] fr [4] = '{32'h40000000, 32'h40400000,
                          32'h40000000, 32'h40900000};

  always #5 clk = ~clk;

  fp_adder_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_subtract(req_subtract),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_flags   (rsp_flags),
    .sticky_flags(sticky_flags),
    .clear_sticky(clear_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input int i, input logic [31:0] a, b,
                      input logic sub);
    req_a[i*32 +: 32]  = a;
    req_b[i*32 +: 32]  = b;
    req_subtract[i]    = sub;
  endtask

  task automatic op(input int i, input logic [31:0] a, b,
                    input logic sub, input logic [31:0] er,
                    input logic [2:0] ef, input logic [2:0] es,
                    input logic clr);
    logic [3:0] oh;
    oh = 4'(1 << i);
    @(negedge clk);
    load(i, a, b, sub);
    req_valid = oh;
    rsp_ready = 1'b1;
    #1 chk("op_ready", 32'(req_ready), 32'(oh));
    @(posedge clk);
    @(negedge clk);
    req_valid    = '0;
    clear_sticky = clr;
    chk("op_valid", 32'(rsp_valid), 32'd1);
    chk("op_result", rsp_result, er);
    chk("op_id", 32'(rsp_id), 32'(i));
    chk("op_flags", 32'(rsp_flags), 32'(ef));
    @(posedge clk);
    @(negedge clk);
    clear_sticky = 1'b0;
    chk("op_drain", 32'(rsp_valid), 32'd0);
    chk("op_sticky", 32'(sticky_flags), 32'(es));
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_sticky = 1'b1;
    @(negedge clk);
    clear_sticky = 1'b0;
    chk("clear", 32'(sticky_flags), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by time %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    req_valid    = 4'b0001;
    req_a        = '0;
    req_b        = '0;
    req_subtract = '0;
    rsp_ready    = 1'b0;
    clear_sticky = 1'b0;
    #12;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_flags", 32'(rsp_flags), 32'd0);
    chk("rst_sticky", 32'(sticky_flags), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;

    op(0, 32'h40400000, 32'h40800000, 1'b0, 32'h40E00000, 3'b000, 3'b000, 1'b0);

    op(2, 32'hFF800000, 32'h7F800000, 1'b0, 32'hFFC00000, 3'b001, 3'b001, 1'b0);
    op(1, 32'h7F800000, 32'h40400000, 1'b0, 32'h7F800000, 3'b010, 3'b011, 1'b0);
    do_clear();
    op(3, 32'h7F800000, 32'h40400000, 1'b0, 32'h7F800000, 3'b010, 3'b010, 1'b1);
    do_clear();

    op(0, 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000, 3'b000, 1'b0);
    op(1, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000, 3'b000, 1'b0);
    op(2, 32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 3'b100, 3'b100, 1'b0);
    op(3, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 3'b100, 1'b0);

    @(negedge clk);
    load(1, fa[1], fb[1], fs[1]);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_valid", 32'(rsp_valid), 32'd1);
    chk("mid_sticky", 32'(sticky_flags), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_sticky", 32'(sticky_flags), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_result", rsp_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) load(i, fa[i], fb[i], fs[i]);
    req_valid = 4'b1100;
    rsp_ready = 1'b1;
    #1 chk("post_rst_ready", 32'(req_ready), 32'h4);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    chk("post_rst_id", 32'(rsp_id), 32'd2);
    chk("post_rst_result", rsp_result, fr[2]);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
      @(posedge clk);
      @(negedge clk);
      chk("rr_id", 32'(rsp_id), 32'(k % 4));
      chk("rr_result", rsp_result, fr[k % 4]);
    end

    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_result", rsp_result, fr[0]);
      chk("bp_id", 32'(rsp_id), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 chk("bp_rel_ready", 32'(req_ready), 32'h2);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    chk("bp_rel_valid", 32'(rsp_valid), 32'd1);
    chk("bp_rel_id", 32'(rsp_id), 32'd1);
    chk("bp_rel_result", rsp_result, fr[1]);
    @(posedge clk);
    @(negedge clk);
    chk("bp_drain", 32'(rsp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
